// File: rtl/serial_adder.sv
// Bit-serial adder: recovers A = D + B one bit per cycle, LSB first,
// using a single full-adder cell and one carry flop.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] d_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               s_bit;
    logic               c_next;
    logic [WIDTH-1:0]   res_shift;

    // Single full-adder cell on the operand LSBs and the stored carry
    always_comb begin
        s_bit     = a_q[0] ^ b_q[0] ^ carry_q;
        c_next    = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        res_shift = {s_bit, res_q[WIDTH-1:1]};
    end

    // Next-state and datapath control; the final shift edge publishes the result
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = d_in;
                    b_d     = b_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d   = res_shift;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = c_next;
                cnt_d   = cnt_q + CNT_W'(1);
                busy_d  = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = res_shift;
                    cout_d  = c_next;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed + random bench for serial_adder with a result scoreboard.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] d_in = '0;
    logic [W-1:0] b_in = '0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [W:0] exp_q[$];

    logic [W-1:0] last_sum;
    logic         last_cout;
    logic         rst_prev  = 1'b1;
    logic         done_prev = 1'b0;
    logic         mon_en    = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .d_in  (d_in),
        .b_in  (b_in),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and checks happen 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // One start pulse, scrambled operands mid-op, bounded wait for done
    task automatic run_op(input logic [W-1:0] d, input logic [W-1:0] b);
        int n;
        d_in  = d;
        b_in  = b;
        start = 1'b1;
        exp_q.push_back(ref_add(d, b));
        step();
        start = 1'b0;
        d_in  = W'($urandom);
        b_in  = W'($urandom);
        n = 0;
        while (!done && n < 3 * W) begin
            step();
            n++;
        end
        chk("op_done_seen", 64'(done), 64'(1));
        chk("op_latency", 64'(n), 64'(W));
        step();
    endtask

    // Scoreboard pop on done; sum/cout must not move except at completion or reset
    always @(negedge clk) begin
        if (done) begin
            chk("done_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                logic [W:0] e;
                e = exp_q.pop_front();
                chk("sb_sum", 64'(sum), 64'(e[W-1:0]));
                chk("sb_cout", 64'(cout), 64'(e[W]));
            end
            chk("done_one_cycle", 64'(done_prev), 64'(0));
        end else if (mon_en && !rst_prev) begin
            chk("sum_stable", 64'({cout, sum}), 64'({last_cout, last_sum}));
        end
        last_sum  = sum;
        last_cout = cout;
        rst_prev  = rst;
        done_prev = done;
    end

    initial begin
        int busy_cnt;
        int done_cnt;
        logic exp_done;

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        rst = 1'b0;
        mon_en = 1'b1;
        step();

        // 0x25 + 0x1A: exact latency and busy window
        d_in  = 8'h25;
        b_in  = 8'h1A;
        start = 1'b1;
        exp_q.push_back(ref_add(8'h25, 8'h1A));
        step();
        start = 1'b0;
        busy_cnt = 0;
        for (int k = 1; k <= int'(W); k++) begin
            if (busy) busy_cnt++;
            chk("basic_done_early", 64'(done), 64'(0));
            step();
        end
        chk("basic_done", 64'(done), 64'(1));
        chk("basic_busy_off", 64'(busy), 64'(0));
        chk("basic_sum", 64'(sum), 64'(8'h3F));
        chk("basic_cout", 64'(cout), 64'(0));
        chk("basic_busy_cycles", 64'(busy_cnt), 64'(W));
        step();
        chk("basic_done_drop", 64'(done), 64'(0));

        // Overflow cases
        run_op(8'hFF, 8'h01);
        chk("ovf1_sum", 64'(sum), 64'(8'h00));
        chk("ovf1_cout", 64'(cout), 64'(1));
        run_op(8'hFF, 8'hFF);
        chk("ovf2_sum", 64'(sum), 64'(8'hFE));
        chk("ovf2_cout", 64'(cout), 64'(1));

        // start held high; operands changed during each shift phase
        d_in  = 8'h10;
        b_in  = 8'h20;
        start = 1'b1;
        exp_q.push_back(ref_add(8'h10, 8'h20));
        exp_q.push_back(ref_add(8'h55, 8'h66));
        step();
        for (int e = 1; e <= 2 * int'(W) + 3; e++) begin
            step();
            exp_done = (e == int'(W)) || (e == 2 * int'(W) + 2);
            chk("held_done", 64'(done), 64'(exp_done));
            if (e == 1) begin
                d_in = 8'h55;
                b_in = 8'h66;
            end
            if (e == int'(W) + 3) begin
                d_in = 8'h01;
                b_in = 8'h02;
            end
            if (e == 2 * int'(W) + 3) start = 1'b0;
        end
        chk("held_sum", 64'(sum), 64'(8'hBB));
        step();
        chk("held_idle", 64'(busy), 64'(0));

        // Reset mid-shift aborts without a done pulse
        d_in  = 8'h77;
        b_in  = 8'h11;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_sum", 64'(sum), 64'(0));
        chk("abort_cout", 64'(cout), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 2 * int'(W); k++) begin
            step();
            if (done) done_cnt++;
        end
        chk("abort_no_done", 64'(done_cnt), 64'(0));

        // First start after reset is accepted
        run_op(8'h3C, 8'hC4);
        chk("post_rst_sum", 64'(sum), 64'(8'h00));
        chk("post_rst_cout", 64'(cout), 64'(1));

        // Random sweep with random idle gaps
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb);
            repeat ($urandom_range(0, 2)) step();
        end

        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the operand and result bit-width (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one addition.
REQ-005 The block SHALL have port d_in, input, WIDTH bits: difference operand (first addend).
REQ-006 The block SHALL have port b_in, input, WIDTH bits: subtrahend operand (second addend).
REQ-007 The block SHALL have port sum, output, WIDTH bits: registered result d_in + b_in (mod 2^WIDTH).
REQ-008 The block SHALL have port cout, output, 1 bit: registered final carry.
REQ-009 The block SHALL have port busy, output, 1 bit: high while bits are being processed.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-011 The block SHALL recover the minuend from a difference/subtrahend pair (A = D + B) bit-serially, LSB first, with one full-adder cell and one carry flip-flop.
REQ-012 The block SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1 at an edge, the block SHALL capture d_in and b_in into shift registers, clear carry and bit counter, and enter SHIFT.
REQ-014 In IDLE with start=0, the block SHALL hold state, and sum/cout SHALL hold their last values.
REQ-015 In SHIFT, each edge SHALL compute s = a0^b0^c and c' = a0&b0 | c&(a0^b0), shift s into the result register at the MSB end, shift both operand registers right by one, and increment the counter.
REQ-016 The WIDTH-th SHIFT edge SHALL move sum (full result register) and cout (final carry) to the outputs and enter DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 If start is sampled at edge 0, done SHALL be high from edge WIDTH to edge WIDTH+1 (latency WIDTH cycles), and sum/cout SHALL be valid from edge WIDTH.
REQ-019 busy SHALL be 1 exactly in SHIFT.
REQ-020 start SHALL be ignored in SHIFT and DONE, and operand input changes during SHIFT SHALL not affect the result.
REQ-021 Overflow SHALL wrap mod 2^WIDTH, with cout=1 when the true sum is >= 2^WIDTH.
REQ-022 sum and cout SHALL change only at the completion edge or at reset.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, and clear counter, carry and shift registers.
REQ-024 rst SHALL take priority over start and over any state, including mid-SHIFT; no done pulse SHALL follow an aborted operation.
REQ-025 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-026 The bench SHALL cover: WIDTH=8, d_in=0x25, b_in=0x1A, start pulse -> done at edge 8, sum=0x3F, cout=0, busy high 8 cycles.
REQ-027 The bench SHALL cover: d_in=0xFF, b_in=0x01 -> sum=0x00, cout=1; then d_in=0xFF, b_in=0xFF -> sum=0xFE, cout=1.
REQ-028 The bench SHALL cover: start held high continuously with operands changed mid-SHIFT -> first result uses captured operands, next operation begins at the IDLE edge after DONE, and done pulses are exactly one cycle each.
REQ-029 The bench SHALL cover: rst asserted at SHIFT cycle 4 -> next edge busy=0, sum=0, cout=0, and no done pulse.
REQ-030 The bench SHALL cover: a random sweep of 1000 operand pairs checked against a reference sum, with sum/cout stable between completions.
